// File: rtl/xadc_drp_poller.sv
// Autonomous DRP master that periodically sweeps four XADC status registers into shadow
// registers. Software reads the shadow copies over Wishbone with a fixed one-cycle latency.
module xadc_drp_poller #(
  parameter int unsigned POLL_DIV    = 100000,
  parameter int unsigned DRP_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [6:0]  drp_daddr_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i
);

  localparam logic [23:0] DivReload = 24'(POLL_DIV - 1);
  localparam logic [9:0]  TmoLast   = 10'(DRP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] div_q, div_d;
  logic [9:0]  tmo_cnt_q, tmo_cnt_d;
  logic [15:0] cache_q [4];
  logic        cache_we;
  logic        en_q, en_d;
  logic        trig_pend_q, trig_pend_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic [15:0] sweep_cnt_q, sweep_cnt_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rd_data;
  logic        advance, tmo_evt;
  logic        busy;
  logic [2:0]  word;
  logic        ctrl_wr, stat_wr;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:2]};

  function automatic logic [6:0] chan_addr(input logic [1:0] idx);
    logic [6:0] a;
    case (idx)
      2'd0:    a = 7'h00;
      2'd1:    a = 7'h01;
      2'd2:    a = 7'h02;
      default: a = 7'h06;
    endcase
    return a;
  endfunction

  assign word    = wb_adr_i[4:2];
  assign ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign ctrl_wr = ack_d & wb_we_i & (word == 3'd4);
  assign stat_wr = ack_d & wb_we_i & (word == 3'd5);
  assign busy    = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    div_d       = div_q;
    tmo_cnt_d   = tmo_cnt_q;
    trig_pend_d = trig_pend_q;
    tmo_flag_d  = tmo_flag_q;
    sweep_cnt_d = sweep_cnt_q;
    daddr_d     = daddr_q;
    en_d        = ctrl_wr ? wb_dat_i[0] : en_q;
    cache_we    = 1'b0;
    advance     = 1'b0;
    tmo_evt     = 1'b0;

    if (ctrl_wr && wb_dat_i[1]) trig_pend_d = 1'b1;
    if (stat_wr && wb_dat_i[0]) tmo_flag_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig_pend_q || (en_q && (div_q == '0))) begin
          state_d     = StIssue;
          idx_d       = 2'd0;
          div_d       = DivReload;
          // A TRIG landing as the pending one is consumed merges into this sweep
          trig_pend_d = 1'b0;
        end else if (en_q) begin
          div_d = div_q - 24'd1;
        end
      end
      StIssue: begin
        state_d   = StWait;
        tmo_cnt_d = '0;
      end
      StWait: begin
        if (drp_drdy_i) begin
          cache_we = 1'b1;
          advance  = 1'b1;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_evt = 1'b1;
          advance = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (idx_q == 2'd3) begin
        state_d     = StIdle;
        sweep_cnt_d = sweep_cnt_q + 16'd1;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = StIssue;
      end
    end

    // A new timeout outranks a coincident clear
    if (tmo_evt) tmo_flag_d = 1'b1;
    if (state_d == StIssue) daddr_d = chan_addr(idx_d);
  end

  always_comb begin
    rd_data = '0;
    case (word)
      3'd0:    rd_data = {16'b0, cache_q[0]};
      3'd1:    rd_data = {16'b0, cache_q[1]};
      3'd2:    rd_data = {16'b0, cache_q[2]};
      3'd3:    rd_data = {16'b0, cache_q[3]};
      3'd4:    rd_data = {31'b0, en_q};
      3'd5:    rd_data = {sweep_cnt_q, 14'b0, busy, tmo_flag_q};
      default: rd_data = '0;
    endcase
    dat_d = ack_d ? rd_data : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      div_q       <= DivReload;
      tmo_cnt_q   <= '0;
      en_q        <= 1'b0;
      trig_pend_q <= 1'b0;
      tmo_flag_q  <= 1'b0;
      sweep_cnt_q <= '0;
      daddr_q     <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      for (int i = 0; i < 4; i++) cache_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      tmo_cnt_q   <= tmo_cnt_d;
      en_q        <= en_d;
      trig_pend_q <= trig_pend_d;
      tmo_flag_q  <= tmo_flag_d;
      sweep_cnt_q <= sweep_cnt_d;
      daddr_q     <= daddr_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      if (cache_we) cache_q[idx_q] <= drp_do_i;
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign wb_err_o    = 1'b0;
  assign drp_daddr_o = daddr_q;
  assign drp_den_o   = (state_q == StIssue);
  assign drp_dwe_o   = 1'b0;
  assign drp_di_o    = '0;

endmodule
